// File: rtl/firtap_sys.sv
// firtap_sys: one systolic FIR tap. out = acc + x*coef (or (x+x2)*coef when PREADD=1),
// with a forwarded x delay line and a daisy-chained shadow coefficient that can be
// swapped atomically into the active coefficient.
//
// Ports:
//   clk, rstn              clock, asynchronous active-low reset
//   in_valid, in_x, in_x2  sample stream (in_x2 used only with PREADD=1)
//   out_x, out_x_valid     sample stream delayed XDLY cycles, for the next tap
//   in_coef, out_coef      shadow coefficient chain input / shadow register value
//   coef_shift, coef_swap  shift the shadow chain / copy shadow into active
//   acc, out, out_valid    partial sum in from upstream, out to downstream
module firtap_sys #(
   parameter int unsigned XW     = 25,
   parameter int unsigned COEFW  = 18,
   parameter int unsigned OUTW   = 48,
   parameter int unsigned XDLY   = 2,
   parameter int unsigned LAT    = 3,
   parameter int unsigned PREADD = 0
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    in_valid,
   input  logic signed [XW-1:0]    in_x,
   input  logic signed [XW-1:0]    in_x2,
   output logic signed [XW-1:0]    out_x,
   output logic                    out_x_valid,
   input  logic signed [COEFW-1:0] in_coef,
   output logic signed [COEFW-1:0] out_coef,
   input  logic                    coef_shift,
   input  logic                    coef_swap,
   input  logic signed [OUTW-1:0]  acc,
   output logic signed [OUTW-1:0]  out,
   output logic                    out_valid
);

   localparam int unsigned PAW = XW + 1;
   localparam int unsigned MW  = PAW + COEFW;

   logic signed [COEFW-1:0] shadow;
   logic signed [COEFW-1:0] active;

   logic signed [XW-1:0]    xd [XDLY];
   logic [XDLY-1:0]         xvd;

   logic signed [XW-1:0]    x_r;
   logic signed [XW-1:0]    x2_r;
   logic signed [COEFW-1:0] coef_r;
   logic [LAT-1:0]          vpipe;

   logic signed [PAW-1:0]   pa_c;
   logic signed [MW-1:0]    mul_c;
   logic signed [OUTW-1:0]  prod_c;
   logic signed [OUTW-1:0]  prod_fin;
   logic signed [OUTW-1:0]  acc_fin;

   // Shadow/active coefficient pair; swap always takes the pre-edge shadow.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         shadow <= '0;
         active <= '0;
      end else begin
         if (coef_shift) shadow <= in_coef;
         if (coef_swap)  active <= shadow;
      end
   end

   assign out_coef = shadow;

   // Forwarded sample delay line, independent of the arithmetic pipe.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < XDLY; i++) xd[i] <= '0;
         xvd <= '0;
      end else begin
         xd[0]  <= in_x;
         xvd[0] <= in_valid;
         for (int i = 1; i < XDLY; i++) begin
            xd[i]  <= xd[i-1];
            xvd[i] <= xvd[i-1];
         end
      end
   end

   assign out_x       = xd[XDLY-1];
   assign out_x_valid = xvd[XDLY-1];

   // Capture stage: sample, partner and coefficient are taken on the same edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         x_r    <= '0;
         x2_r   <= '0;
         coef_r <= '0;
         vpipe  <= '0;
      end else begin
         x_r      <= in_x;
         x2_r     <= in_x2;
         coef_r   <= active;
         vpipe[0] <= in_valid;
         for (int i = 1; i < LAT; i++) vpipe[i] <= vpipe[i-1];
      end
   end

   assign out_valid = vpipe[LAT-1];

   // Pre-add at XW+1 bits (cannot overflow), full-precision product, bubble forces zero.
   always_comb begin
      pa_c   = PAW'(x_r) + ((PREADD != 0) ? PAW'(x2_r) : PAW'(0));
      mul_c  = pa_c * coef_r;
      prod_c = vpipe[0] ? OUTW'(mul_c) : '0;
   end

   // Product delay so the final add lands exactly LAT cycles after capture.
   if (LAT > 2) begin : g_pd
      logic signed [OUTW-1:0] pd [LAT-2];
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            for (int i = 0; i < LAT - 2; i++) pd[i] <= '0;
         end else begin
            pd[0] <= prod_c;
            for (int i = 1; i < LAT - 2; i++) pd[i] <= pd[i-1];
         end
      end
      assign prod_fin = pd[LAT-3];
   end else begin : g_pd_none
      assign prod_fin = prod_c;
   end

   // acc arrives LAT-XDLY cycles after the sample; XDLY-1 stages plus the sum register
   // line it up with the product.
   if (XDLY > 1) begin : g_ad
      logic signed [OUTW-1:0] ad [XDLY-1];
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            for (int i = 0; i < XDLY - 1; i++) ad[i] <= '0;
         end else begin
            ad[0] <= acc;
            for (int i = 1; i < XDLY - 1; i++) ad[i] <= ad[i-1];
         end
      end
      assign acc_fin = ad[XDLY-2];
   end else begin : g_ad_none
      assign acc_fin = acc;
   end

   // Final accumulate, wrapping modulo 2^OUTW.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) out <= '0;
      else       out <= acc_fin + prod_fin;
   end

endmodule

// File: tb/tb_firtap_sys.sv
// tb_firtap_sys: directed bench for firtap_sys. Drives a default tap, a pre-add tap
// sharing the same stimulus, and a 4-tap chain.
module tb_firtap_sys;

   localparam int unsigned LAT  = 3;
   localparam int unsigned XDLY = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rstn;
   logic                v;
   logic signed [24:0]  x, x2;
   logic signed [17:0]  cin;
   logic                sh, sw;
   logic signed [47:0]  acc;

   logic signed [24:0]  d_x, p_x;
   logic                d_xv, p_xv, d_ov, p_ov;
   logic signed [17:0]  d_coef, p_coef;
   logic signed [47:0]  d_out, p_out;

   logic                c_v, c_sh, c_sw;
   logic signed [24:0]  c_x;
   logic signed [24:0]  c_x2;
   logic signed [17:0]  c_cin;
   logic signed [47:0]  c_acc0;
   logic signed [24:0]  c_xo  [4];
   logic                c_xvo [4];
   logic signed [17:0]  c_co  [4];
   logic signed [47:0]  c_out [4];
   logic                c_ov  [4];

   int n_run  = 0;
   int n_fail = 0;

   firtap_sys u_dut (
      .clk(clk), .rstn(rstn), .in_valid(v), .in_x(x), .in_x2(x2),
      .out_x(d_x), .out_x_valid(d_xv), .in_coef(cin), .out_coef(d_coef),
      .coef_shift(sh), .coef_swap(sw), .acc(acc), .out(d_out), .out_valid(d_ov)
   );

   firtap_sys #(.PREADD(1)) u_pre (
      .clk(clk), .rstn(rstn), .in_valid(v), .in_x(x), .in_x2(x2),
      .out_x(p_x), .out_x_valid(p_xv), .in_coef(cin), .out_coef(p_coef),
      .coef_shift(sh), .coef_swap(sw), .acc(acc), .out(p_out), .out_valid(p_ov)
   );

   for (genvar k = 0; k < 4; k++) begin : g_chain
      firtap_sys u_tap (
         .clk(clk), .rstn(rstn),
         .in_valid(k == 0 ? c_v : c_xvo[(k == 0) ? 0 : k-1]),
         .in_x(k == 0 ? c_x : c_xo[(k == 0) ? 0 : k-1]),
         .in_x2(c_x2),
         .out_x(c_xo[k]), .out_x_valid(c_xvo[k]),
         .in_coef(k == 0 ? c_cin : c_co[(k == 0) ? 0 : k-1]),
         .out_coef(c_co[k]),
         .coef_shift(c_sh), .coef_swap(c_sw),
         .acc(k == 0 ? c_acc0 : c_out[(k == 0) ? 0 : k-1]),
         .out(c_out[k]), .out_valid(c_ov[k])
      );
   end

   task automatic chk(input string tag, input longint got, input longint exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Shift a coefficient into the shadow, then swap it into active.
   task automatic load(input logic signed [17:0] c);
      cin = c; sh = 1'b1; step(1);
      sh = 1'b0; sw = 1'b1; step(1);
      sw = 1'b0;
   endtask

   // One-cycle sample with acc held; returns LAT edges after presentation.
   task automatic pulse(input logic signed [24:0] xv, input logic signed [24:0] x2v,
                        input logic signed [47:0] av, input logic vv);
      x = xv; x2 = x2v; acc = av; v = vv;
      step(1);
      v = 1'b0; x = '0; x2 = '0;
      step(LAT - 1);
   endtask

   initial begin
      rstn = 1'b0; v = 1'b0; x = '0; x2 = '0; cin = '0; sh = 1'b0; sw = 1'b0; acc = '0;
      c_v = 1'b0; c_x = '0; c_x2 = '0; c_cin = '0; c_sh = 1'b0; c_sw = 1'b0; c_acc0 = '0;
      step(2);
      chk("rst_out",      longint'(d_out),  0);
      chk("rst_out_valid", longint'(d_ov),  0);
      chk("rst_out_x",    longint'(d_x),    0);
      chk("rst_coef",     longint'(d_coef), 0);
      rstn = 1'b1;
      step(1);

      // impulse: coef 3, x=5
      cin = 18'sd3; sh = 1'b1; step(1);
      chk("shift_out_coef", longint'(d_coef), 3);
      chk("pre_shift_out_coef", longint'(p_coef), 3);
      sh = 1'b0; sw = 1'b1; step(1); sw = 1'b0;
      x = 25'sd5; v = 1'b1; acc = '0; step(1);
      v = 1'b0; x = '0;
      step(1);
      chk("imp_out_x",       longint'(d_x),  5);
      chk("imp_out_x_valid", longint'(d_xv), 1);
      chk("imp_pre_out_x",   longint'(p_x),  5);
      chk("imp_pre_x_valid", longint'(p_xv), 1);
      chk("imp_early_valid", longint'(d_ov), 0);
      step(1);
      chk("imp_out",       longint'(d_out), 15);
      chk("imp_out_valid", longint'(d_ov),  1);
      step(1);
      chk("imp_valid_drop", longint'(d_ov), 0);

      // mid-stream async reset
      acc = 48'sd7; x = 25'sd5; v = 1'b1;
      step(2);
      #2 rstn = 1'b0;
      #1;
      chk("mid_rst_out",     longint'(d_out),  0);
      chk("mid_rst_out_x",   longint'(d_x),    0);
      chk("mid_rst_x_valid", longint'(d_xv),   0);
      chk("mid_rst_coef",    longint'(d_coef), 0);
      chk("mid_rst_valid",   longint'(d_ov),   0);
      v = 1'b0; x = '0; acc = '0;
      #1 rstn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(1);
         chk("post_rst_valid", longint'(d_ov),  0);
         chk("post_rst_out",   longint'(d_out), 0);
      end

      // signed extremes
      load(18'sh20000);
      pulse(25'sh1000000, '0, '0, 1'b1);
      chk("min_x_min_coef", longint'(d_out), longint'(1) <<< 41);
      load(18'sd1);
      pulse(25'sd1, '0, 48'sh7FFF_FFFF_FFFF, 1'b1);
      chk("acc_wrap", longint'(d_out), -(longint'(1) <<< 47));
      acc = '0;

      // bubble passes acc through
      pulse(25'sd7, '0, 48'sd100, 1'b0);
      chk("bubble_out",   longint'(d_out), 100);
      chk("bubble_valid", longint'(d_ov),  0);
      acc = '0;

      // swap 2 -> 4 between back-to-back samples
      load(18'sd2);
      cin = 18'sd4; sh = 1'b1; step(1); sh = 1'b0;
      x = 25'sd1; v = 1'b1; sw = 1'b1; step(1);
      sw = 1'b0; step(1);
      v = 1'b0; x = '0;
      step(1);
      chk("swap_first",       longint'(d_out), 2);
      chk("swap_first_valid", longint'(d_ov),  1);
      step(1);
      chk("swap_second",       longint'(d_out), 4);
      chk("swap_second_valid", longint'(d_ov),  1);

      // simultaneous shift+swap: active <- old shadow, shadow <- in_coef
      cin = 18'sd9; sh = 1'b1; step(1);
      cin = 18'sd5; sw = 1'b1; step(1);
      sh = 1'b0; sw = 1'b0;
      chk("shsw_out_coef", longint'(d_coef), 5);
      pulse(25'sd1, '0, '0, 1'b1);
      chk("shsw_active", longint'(d_out), 9);

      // pre-adder
      load(18'sd2);
      pulse(25'sd10, -25'sd3, '0, 1'b1);
      chk("preadd_out",    longint'(p_out), 14);
      chk("preadd_valid",  longint'(p_ov),  1);
      chk("nopre_ignores", longint'(d_out), 20);
      load(18'sd1);
      pulse(25'sh0FFFFFF, 25'sh0FFFFFF, '0, 1'b1);
      chk("preadd_max", longint'(p_out), (longint'(1) <<< 25) - 2);
      chk("nopre_max",  longint'(d_out), (longint'(1) <<< 24) - 1);

      // 4-tap chain: shift 1..4, swap, impulse
      for (int i = 1; i <= 4; i++) begin
         c_cin = 18'(i); c_sh = 1'b1; step(1);
      end
      c_sh = 1'b0;
      chk("chain_coef0", longint'(c_co[0]), 4);
      chk("chain_coef1", longint'(c_co[1]), 3);
      chk("chain_coef2", longint'(c_co[2]), 2);
      chk("chain_coef3", longint'(c_co[3]), 1);
      c_sw = 1'b1; step(1); c_sw = 1'b0;
      c_x = 25'sd1; c_v = 1'b1; step(1);
      c_v = 1'b0; c_x = '0;
      step(2);
      chk("chain_tap0", longint'(c_out[0]), 4);
      chk("chain_tap0_valid", longint'(c_ov[0]), 1);
      step(2);
      chk("chain_tap1", longint'(c_out[1]), 7);
      step(2);
      chk("chain_tap2", longint'(c_out[2]), 9);
      step(1);
      chk("chain_early_valid", longint'(c_ov[3]), 0);
      step(1);
      chk("chain_tap3", longint'(c_out[3]), 10);
      chk("chain_tap3_valid", longint'(c_ov[3]), 1);

      // chain shift+swap together: actives keep old shadows 4,3,2,1
      c_cin = 18'sd7; c_sh = 1'b1; c_sw = 1'b1; step(1);
      c_sh = 1'b0; c_sw = 1'b0;
      chk("chain_shsw_coef0", longint'(c_co[0]), 7);
      chk("chain_shsw_coef3", longint'(c_co[3]), 2);
      c_x = 25'sd2; c_v = 1'b1; step(1);
      c_v = 1'b0; c_x = '0;
      step(8);
      chk("chain_shsw_out", longint'(c_out[3]), 20);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
